// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package pc_fetch_pkg;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] inst_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  localparam pc_t PC_STEP = 32'd4;

  // Sequential successor; wraps naturally at 32 bits.
  function automatic pc_t pc_next(input pc_t pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a single-cycle flush; DEPTH must be a power of two.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & (cnt_q != '0);
  assign do_push = push_i & ((cnt_q != (AW+1)'(DEPTH)) | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC holder: issues in-order imem reads, buffers {pc, inst} for decode, handles redirects.
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirects are ignored and flagged on misalign_err.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter pc_t RESET_PC   = 32'd0,
  parameter int  FIFO_DEPTH = 4,
  parameter int  MAX_OUTST  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  input  logic        inst_ready
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int RCW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW  = RCW + 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  fetch_state_e  state_q, state_d;
  pc_t           fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, credit_sum;
  logic          req_fire, rsp_ok, redirect_eff;
  pc_t           redirect_tgt, pcq_head;
  inst_t         rsp_word;
  logic [63:0]   rsp_head;
  logic          rsp_empty, pcq_empty;
  logic [RCW-1:0] rsp_cnt, pcq_cnt;
  logic          unused_pcq;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q;
  assign redirect_eff = redirect_valid & (redirect_pc[1:0] == 2'b00);
  assign redirect_tgt = redirect_pc;
  assign misalign_err = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else if (redirect_valid && redirect_pc[1:0] != 2'b00) misalign_q <= 1'b1;
  end
`else
  logic unused_lsb;
  assign redirect_eff = redirect_valid;
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign unused_lsb   = ^redirect_pc[1:0];
`endif

  assign req_fire   = imem_req_valid & imem_req_ready;
  // Responses with nothing in flight belong to the memory's own reset domain.
  assign rsp_ok     = imem_rsp_valid & (outst_q != '0);
  assign rsp_word   = imem_rsp_data;
  assign credit_sum = outst_q + CW'(rsp_cnt);
  assign outst_d    = outst_q + CW'(req_fire) - CW'(rsp_ok);
  assign unused_pcq = ^{pcq_empty, pcq_cnt};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (req_fire) fetch_pc_d = pc_next(fetch_pc_q);
    if (rsp_ok && drop_q != '0) drop_d = drop_q - CNT_ONE;
    // Every request still in flight after a redirect belongs to the stale stream.
    if (redirect_eff) begin
      fetch_pc_d = redirect_tgt;
      drop_d     = outst_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fetch_en) state_d = FETCH;
      FETCH:   if (redirect_eff && outst_d != '0)     state_d = FLUSH;
               else if (!fetch_en && outst_q == '0)  state_d = IDLE;
      FLUSH:   if (drop_d == '0) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = (state_q == FETCH) & fetch_en & !redirect_valid & (drop_q == '0)
                   & (outst_q < CW'(MAX_OUTST)) & (credit_sum < CW'(FIFO_DEPTH));
  end

  assign imem_req_addr = fetch_pc_q;

  // In-flight PCs are never flushed: dropped responses still retire their entry.
  fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_pc_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (1'b0),
    .push_i  (req_fire),
    .wdata_i (fetch_pc_q),
    .pop_i   (rsp_ok),
    .rdata_o (pcq_head),
    .empty_o (pcq_empty),
    .count_o (pcq_cnt)
  );

  fetch_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_rsp_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_eff),
    .push_i  (rsp_ok & (drop_q == '0)),
    .wdata_i ({pcq_head, rsp_word}),
    .pop_i   (inst_valid & inst_ready),
    .rdata_o (rsp_head),
    .empty_o (rsp_empty),
    .count_o (rsp_cnt)
  );

  assign inst_valid = !rsp_empty;
  assign inst_pc    = rsp_head[63:32];
  assign inst_data  = rsp_head[31:0];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: cycle table for streaming plus hand sequences for corners.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, redirect_valid, imem_req_ready, inst_ready;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_rsp_valid, inst_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, inst_pc, inst_data;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_err;
`endif

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'd0), .FIFO_DEPTH(4), .MAX_OUTST(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .inst_ready     (inst_ready)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign_err   (misalign_err)
`endif
  );

  // Memory: in-order, 1-cycle latency when rsp_en, word = addr + 0x1000_0000.
  logic        rsp_en;
  logic [31:0] mq[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'd0;
    end else begin
      if (imem_rsp_valid) void'(mq.pop_front());
      if (imem_req_valid && imem_req_ready) mq.push_back(imem_req_addr);
      if (rsp_en && mq.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mq[0] + 32'h1000_0000;
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  logic [31:0] fire_q[$];
  logic [63:0] del_q[$];
  always @(posedge clk) begin
    if (rst_n) begin
      if (imem_req_valid && imem_req_ready) fire_q.push_back(imem_req_addr);
      if (inst_valid && inst_ready) del_q.push_back({inst_pc, inst_data});
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_fires(input int n, input int budget);
    int k = 0;
    while (fire_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("fire_count", 32'(fire_q.size()), 32'(n));
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic drain();
    fetch_en   = 1'b0;
    inst_ready = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  typedef struct {
    logic        fe, rdy, ir;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc, exp_data;
  } vec_t;
  vec_t vecs[9];

  logic [31:0] exp_mis_addr;

  initial begin
    vecs[0] = '{1, 1, 1, 0, 32'h0,  0, 32'h0,  32'h0};
    vecs[1] = '{1, 1, 1, 1, 32'h0,  0, 32'h0,  32'h0};
    vecs[2] = '{1, 1, 1, 1, 32'h4,  0, 32'h0,  32'h0};
    vecs[3] = '{1, 1, 1, 1, 32'h8,  1, 32'h0,  32'h1000_0000};
    vecs[4] = '{1, 1, 1, 1, 32'hC,  1, 32'h4,  32'h1000_0004};
    vecs[5] = '{1, 1, 1, 1, 32'h10, 1, 32'h8,  32'h1000_0008};
    vecs[6] = '{0, 1, 1, 0, 32'h0,  1, 32'hC,  32'h1000_000C};
    vecs[7] = '{0, 1, 1, 0, 32'h0,  1, 32'h10, 32'h1000_0010};
    vecs[8] = '{0, 1, 1, 0, 32'h0,  0, 32'h0,  32'h0};

    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_req_ready = 1'b0; inst_ready = 1'b0; rsp_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
    chk("reset_inst_valid", 32'(inst_valid), 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("reset_misalign", 32'(misalign_err), 32'd0);
`endif
    rst_n = 1'b1;
    rsp_en = 1'b1;

    // Streaming table: one row per cycle.
    foreach (vecs[i]) begin
      fetch_en = vecs[i].fe; imem_req_ready = vecs[i].rdy; inst_ready = vecs[i].ir;
      #1;
      chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].exp_rv));
      if (vecs[i].exp_rv) chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_inst_valid", i), 32'(inst_valid), 32'(vecs[i].exp_iv));
      if (vecs[i].exp_iv) begin
        chk($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].exp_pc);
        chk($sformatf("v%0d_inst_data", i), inst_data, vecs[i].exp_data);
      end
      @(negedge clk);
    end

    // Credit limit: decode stalled, buffer fills with exactly 4 entries.
    fire_q.delete(); del_q.delete();
    fetch_en = 1'b1; inst_ready = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("credit_fires", 32'(fire_q.size()), 32'd4);
    chk("credit_first_addr", fire_q[0], 32'h14);
    chk("credit_last_addr", fire_q[3], 32'h20);
    chk("credit_req_valid", 32'(imem_req_valid), 32'd0);
    chk("credit_head_pc", inst_pc, 32'h14);
    chk("credit_head_data", inst_data, 32'h1000_0014);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    begin
      int k = 0;
      #1;
      while (!imem_req_valid && k < 5) begin
        @(negedge clk); #1; k++;
      end
    end
    chk("credit_resume_valid", 32'(imem_req_valid), 32'd1);
    chk("credit_resume_addr", imem_req_addr, 32'h24);
    drain();
    chk("credit_delivered", 32'(del_q.size()), 32'd4);
    chk("credit_last_pc", del_q[3][63:32], 32'h20);

    // Request stall: address held while not ready.
    redirect_to(32'h10);
    fire_q.delete(); del_q.delete();
    imem_req_ready = 1'b0; fetch_en = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_valid", c), 32'(imem_req_valid), 32'd1);
      chk($sformatf("stall%0d_addr", c), imem_req_addr, 32'h10);
      @(negedge clk);
    end
    imem_req_ready = 1'b1;
    #1;
    chk("stall_accept_addr", imem_req_addr, 32'h10);
    @(negedge clk);
    #1;
    chk("stall_next_addr", imem_req_addr, 32'h14);
    chk("stall_fires", 32'(fire_q.size()), 32'd1);
    drain();

    // Redirect with 2 outstanding and one buffered entry.
    redirect_to(32'h80);
    fire_q.delete(); del_q.delete();
    fetch_en = 1'b1; imem_req_ready = 1'b1; rsp_en = 1'b1; inst_ready = 1'b0;
    wait_fires(1, 10);
    rsp_en = 1'b0;
    wait_fires(3, 10);
    #1;
    chk("redir_pre_valid", 32'(inst_valid), 32'd1);
    chk("redir_pre_pc", inst_pc, 32'h80);
    redirect_valid = 1'b1; redirect_pc = 32'h100; rsp_en = 1'b1;
    #1;
    chk("redir_req_blocked", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0; inst_ready = 1'b1;
    #1;
    chk("redir_flushed", 32'(inst_valid), 32'd0);
    chk("redir_no_req", 32'(imem_req_valid), 32'd0);
    begin
      int k = 0;
      while (del_q.size() == 0 && k < 20) begin
        @(negedge clk); k++;
      end
    end
    chk("redir_delivered", 32'(del_q.size() > 0), 32'd1);
    chk("redir_first_pc", del_q[0][63:32], 32'h100);
    chk("redir_first_data", del_q[0][31:0], 32'h1000_0100);
    chk("redir_next_fire", fire_q[3], 32'h100);
    drain();

    // Wrap-around at the top of the address space.
    redirect_to(32'hFFFF_FFFC);
    fire_q.delete(); del_q.delete();
    fetch_en = 1'b1; inst_ready = 1'b1;
    wait_fires(2, 10);
    fetch_en = 1'b0;
    repeat (8) @(negedge clk);
    chk("wrap_addr0", fire_q[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", fire_q[1], 32'h0);
    chk("wrap_delivered", 32'(del_q.size()), 32'd2);
    chk("wrap_pc0", del_q[0][63:32], 32'hFFFF_FFFC);
    chk("wrap_data0", del_q[0][31:0], 32'h0FFF_FFFC);
    chk("wrap_pc1", del_q[1][63:32], 32'h0);

    // Misaligned redirect target.
    redirect_to(32'h102);
    fire_q.delete(); del_q.delete();
    fetch_en = 1'b1;
    wait_fires(1, 10);
    fetch_en = 1'b0;
    #1;
`ifdef FETCH_MISALIGN_CHK_EN
    exp_mis_addr = 32'h4;
    chk("misalign_flag", 32'(misalign_err), 32'd1);
`else
    exp_mis_addr = 32'h100;
`endif
    chk("misalign_addr", fire_q[0], exp_mis_addr);
    drain();

    // Reset in the middle of traffic.
    fetch_en = 1'b1; inst_ready = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; inst_ready = 1'b1;
    fire_q.delete(); del_q.delete();
    wait_fires(1, 10);
    chk("midrst_first_addr", fire_q[0], 32'h0);
    drain();
    chk("midrst_first_pc", del_q[0][63:32], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
